// File: rtl/pio_input_irq.sv
// Purpose : Avalon-MM PIO input slave; synchronises and debounces in_port, captures edges and raises a maskable irq.
// Latency : readdata 1 cycle after chipselect; in_port step to DATA in 2+DEBOUNCE_CYCLES edges (3 when bypassed).
// Backpres: none; the slave never stalls (no waitrequest), every access completes in a fixed single cycle.
//
// Ports:
//   clk, reset            single clock domain, synchronous active-high reset
//   address[1:0]          word select: 0 DATA, 1 reserved, 2 IRQ_MASK, 3 EDGE_CAPTURE (W1C)
//   chipselect, write     access qualifiers; reads have no strobe, chipselect alone selects a read
//   writedata[31:0]       write data; bits at and above WIDTH are dropped
//   readdata[31:0]        registered read data, zero when not selected
//   in_port[WIDTH-1:0]    asynchronous external inputs (switches / buttons)
//   irq                   level interrupt, OR of masked sticky edge bits
module pio_input_irq #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    // A zero-width counter is not legal, so the bypass case keeps a 1-bit width it never uses.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;

    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;
    logic [31:0]      rd_mux;

    // Bits of writedata above WIDTH are intentionally discarded.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    // Two-flop synchroniser, nothing between the stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) begin
                    stable <= '0;
                end else begin
                    stable <= sync2;
                end
            end
        end else begin : g_debounce
            // Counter tracks how long sync2 has disagreed with stable; it is
            // only accepted after DEBOUNCE_CYCLES consecutive mismatch cycles.
            logic [CNT_W-1:0] cnt [WIDTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    stable <= '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (sync2[i] == stable[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            stable[i] <= sync2[i];
                            cnt[i]    <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + 1'b1;
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

    always_comb begin
        edge_evt = rise | fall;
        if (EDGE_TYPE == 0) begin
            edge_evt = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_evt = fall;
        end
    end

    assign wr_en = chipselect & write;
    assign w1c   = (wr_en && (address == ADDR_EDGE)) ? writedata[WIDTH-1:0] : '0;

    // A new event on a bit overrides a simultaneous software clear of that bit,
    // so an edge arriving during the clear is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture <= '0;
        end else begin
            edge_capture <= (edge_capture & ~w1c) | edge_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
        end else if (wr_en && (address == ADDR_MASK)) begin
            irq_mask <= writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (address)
            ADDR_DATA: rd_mux = 32'(stable);
            ADDR_MASK: rd_mux = 32'(irq_mask);
            ADDR_EDGE: rd_mux = 32'(edge_capture);
            default:   rd_mux = 32'd0;
        endcase
    end

    // No read strobe: any selected cycle returns data, unselected cycles return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= 32'd0;
        end else if (chipselect) begin
            readdata <= rd_mux;
        end else begin
            readdata <= 32'd0;
        end
    end

    assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_pio_input_irq.sv
// Purpose : directed bench for pio_input_irq; instance A debounced rising capture, instance B bypass any-edge.
// Latency : read expectations are queued at issue and retired one clock later when readdata is registered.
// Backpres: none; the bench drives one access at a time.
module tb_pio_input_irq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [1:0]  a_addr = '0;
    logic        a_cs = 1'b0;
    logic        a_wr = 1'b0;
    logic [31:0] a_wdata = '0;
    logic [31:0] a_rdata;
    logic [7:0]  a_in = '0;
    logic        a_irq;

    logic [1:0]  b_addr = '0;
    logic        b_cs = 1'b0;
    logic        b_wr = 1'b0;
    logic [31:0] b_wdata = '0;
    logic [31:0] b_rdata;
    logic [7:0]  b_in = '0;
    logic        b_irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    pio_input_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_dut_a (
        .clk        (clk),
        .reset      (reset),
        .address    (a_addr),
        .chipselect (a_cs),
        .write      (a_wr),
        .writedata  (a_wdata),
        .readdata   (a_rdata),
        .in_port    (a_in),
        .irq        (a_irq)
    );

    pio_input_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_dut_b (
        .clk        (clk),
        .reset      (reset),
        .address    (b_addr),
        .chipselect (b_cs),
        .write      (b_wr),
        .writedata  (b_wdata),
        .readdata   (b_rdata),
        .in_port    (b_in),
        .irq        (b_irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input bit dut, input logic [1:0] addr, input logic [31:0] exp,
                      input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        if (!dut) begin
            a_cs = 1'b1; a_wr = 1'b0; a_addr = addr;
        end else begin
            b_cs = 1'b1; b_wr = 1'b0; b_addr = addr;
        end
        tick();
        a_cs = 1'b0;
        b_cs = 1'b0;
        chk(tag_q.pop_front(), dut ? b_rdata : a_rdata, exp_q.pop_front());
    endtask

    task automatic wr(input bit dut, input logic [1:0] addr, input logic [31:0] data);
        if (!dut) begin
            a_cs = 1'b1; a_wr = 1'b1; a_addr = addr; a_wdata = data;
        end else begin
            b_cs = 1'b1; b_wr = 1'b1; b_addr = addr; b_wdata = data;
        end
        tick();
        a_cs = 1'b0; a_wr = 1'b0;
        b_cs = 1'b0; b_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_rdata_a", a_rdata, 32'h0);
        chk("rst_rdata_b", b_rdata, 32'h0);
        chk("rst_irq_a", 32'(a_irq), 32'h0);
        chk("rst_irq_b", 32'(b_irq), 32'h0);
        reset = 1'b0;
        rd(0, 2'd0, 32'h0, "idle_data");
        rd(0, 2'd1, 32'h0, "idle_rsvd");
        rd(0, 2'd2, 32'h0, "idle_mask");
        rd(0, 2'd3, 32'h0, "idle_edge");
        wr(0, 2'd1, 32'hFFFF_FFFF);
        rd(0, 2'd1, 32'h0, "rsvd_write_ignored");
        tick();
        chk("rdata_unselected", a_rdata, 32'h0);

        // Debounce latency: step at t, stable at edge t+6
        a_in = 8'h01;
        repeat (5) tick();
        rd(0, 2'd0, 32'h0, "dbnc_early");
        rd(0, 2'd0, 32'h1, "dbnc_data");
        tick();
        rd(0, 2'd3, 32'h1, "ec_first");
        chk("irq_mask_zero", 32'(a_irq), 32'h0);
        wr(0, 2'd3, 32'h1);
        rd(0, 2'd3, 32'h0, "ec_w1c");

        // Three-cycle glitch on bit 1 must be rejected
        a_in = 8'h03;
        repeat (3) tick();
        a_in = 8'h01;
        repeat (10) tick();
        rd(0, 2'd0, 32'h1, "glitch_data");
        rd(0, 2'd3, 32'h0, "glitch_ec");

        // Rising capture with irq
        wr(0, 2'd2, 32'h1);
        rd(0, 2'd2, 32'h1, "mask_rd");
        a_in = 8'h00;
        repeat (8) tick();
        rd(0, 2'd3, 32'h0, "fall_ignored");
        rd(0, 2'd0, 32'h0, "data_low");
        a_in = 8'h01;
        repeat (6) tick();
        chk("irq_pre", 32'(a_irq), 32'h0);
        tick();
        chk("irq_rise", 32'(a_irq), 32'h1);
        rd(0, 2'd3, 32'h1, "ec_rise");
        wr(0, 2'd3, 32'h1);
        chk("irq_clear", 32'(a_irq), 32'h0);
        rd(0, 2'd3, 32'h0, "ec_cleared");

        // Mask gating, upper mask bits not stored
        wr(0, 2'd2, 32'hFFFF_FF00);
        rd(0, 2'd2, 32'h0, "mask_upper");
        a_in = 8'h09;
        repeat (9) tick();
        rd(0, 2'd3, 32'h8, "ec_bit3");
        chk("irq_gated", 32'(a_irq), 32'h0);
        rd(0, 2'd0, 32'h9, "data_09");
        wr(0, 2'd2, 32'h8);
        chk("irq_unmask", 32'(a_irq), 32'h1);

        // Clear of bits 3 and 1 lands on the same edge that sets bit 1
        a_in = 8'h0B;
        repeat (6) tick();
        wr(0, 2'd3, 32'h0A);
        rd(0, 2'd3, 32'h2, "sim_set_wins");
        chk("irq_after_sim", 32'(a_irq), 32'h0);

        // Bypass debounce, any-edge capture
        b_in = 8'h04;
        repeat (2) tick();
        rd(1, 2'd0, 32'h0, "b_lat_early");
        rd(1, 2'd0, 32'h4, "b_lat");
        rd(1, 2'd3, 32'h4, "b_rise");
        wr(1, 2'd3, 32'h4);
        rd(1, 2'd3, 32'h0, "b_w1c");
        b_in = 8'h00;
        repeat (5) tick();
        rd(1, 2'd3, 32'h4, "b_fall");
        rd(1, 2'd0, 32'h0, "b_data_low");
        wr(1, 2'd2, 32'h4);
        chk("b_irq", 32'(b_irq), 32'h1);

        // Reset in the middle of a debounce count
        a_in = 8'h1B;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_rdata", a_rdata, 32'h0);
        chk("mid_rst_irq_a", 32'(a_irq), 32'h0);
        chk("mid_rst_irq_b", 32'(b_irq), 32'h0);
        rd(0, 2'd2, 32'h0, "mid_rst_mask");
        rd(0, 2'd3, 32'h0, "mid_rst_ec");
        rd(0, 2'd0, 32'h0, "mid_rst_data");
        rd(1, 2'd2, 32'h0, "mid_rst_b_mask");
        rd(1, 2'd3, 32'h0, "mid_rst_b_ec");
        rd(0, 2'd0, 32'h0, "post_rst_early");
        rd(0, 2'd0, 32'h1B, "post_rst_data");
        rd(0, 2'd3, 32'h1B, "post_rst_rise");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
